// File: rtl/command_sequencer_pkg.sv
// command_sequencer_pkg: opcodes, sequencer states and error-bit indices.
package command_sequencer_pkg;
    typedef enum logic [7:0] {
        OP_WRITE      = 8'h01,
        OP_READ       = 8'h02,
        OP_STREAM     = 8'h03,
        OP_BIND_READ  = 8'h04,
        OP_BIND_WRITE = 8'h05,
        OP_BIND_INTR  = 8'h06,
        OP_TRANSFER   = 8'h07,
        OP_REPEAT     = 8'h08
    } opcode_t;
    typedef enum logic [2:0] {IDLE, WR, RD, ST_WR, ST_RD} seq_state_t;
    localparam int ERR_TIMEOUT = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_UNBOUND = 2;
endpackage

// File: rtl/command_sequencer_if.sv
// command_sequencer_if: memory-mapped bus between the sequencer and the core.
interface command_sequencer_if #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int VALUE_WIDTH = 32
);
    logic req;
    logic we;
    logic ack;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [VALUE_WIDTH-1:0] wdata;
    logic [VALUE_WIDTH-1:0] rdata;
    modport master(output req, we, addr, wdata, input ack, rdata);
    modport slave(input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/command_sequencer_ack_watchdog.sv
// command_sequencer_ack_watchdog: counts request cycles, flags the last one before abort.
module command_sequencer_ack_watchdog #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (!start_i || clear_i) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign expired_o = start_i && !clear_i && cnt_q == CW'(ACK_TIMEOUT - 1);
endmodule

// File: rtl/command_sequencer.sv
// command_sequencer: executes decoded host commands as bus transactions.
module command_sequencer
    import command_sequencer_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 8,
    parameter int ADDRESS_WIDTH = 24,
    parameter int VALUE_WIDTH = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cmd_valid_i,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    input  logic [VALUE_WIDTH-1:0] value_i,
    output logic cmd_ready_o,
    command_sequencer_if.master mem,
    output logic [VALUE_WIDTH-1:0] result_o,
    output logic [VALUE_WIDTH-1:0] stream_o,
    output logic [ADDRESS_WIDTH-1:0] intr_addr_o,
    output logic intr_en_o,
    input  logic err_clr_i,
    output logic [2:0] err_o
);
    seq_state_t state_q, state_d;
    logic req_q, req_d, we_q, we_d, rd_ok_q, rd_ok_d, wr_ok_q, wr_ok_d, intr_en_q, intr_en_d, expired;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, st_addr_q, st_addr_d, bind_rd_q, bind_rd_d;
    logic [ADDRESS_WIDTH-1:0] bind_wr_q, bind_wr_d, intr_addr_q, intr_addr_d;
    logic [VALUE_WIDTH-1:0] wdata_q, wdata_d, result_q, result_d, stream_q, stream_d;
    logic [2:0] err_q, err_d;
    logic [7:0] op;
    assign op = 8'(instruction_i);
    command_sequencer_ack_watchdog #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wd (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(req_q), .clear_i(mem.ack), .expired_o(expired)
    );
    always_comb begin
        state_d = state_q;
        req_d = req_q;
        we_d = we_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        st_addr_d = st_addr_q;
        result_d = result_q;
        stream_d = stream_q;
        bind_rd_d = bind_rd_q;
        bind_wr_d = bind_wr_q;
        rd_ok_d = rd_ok_q;
        wr_ok_d = wr_ok_q;
        intr_addr_d = intr_addr_q;
        intr_en_d = intr_en_q;
        err_d = err_clr_i ? '0 : err_q;
        if (cmd_valid_i && state_q != IDLE) err_d[ERR_OVERRUN] = 1'b1;
        if (state_q == IDLE) begin
            if (cmd_valid_i) begin
                case (op)
                    OP_WRITE: begin
                        state_d = WR;
                        req_d = 1'b1;
                        we_d = 1'b1;
                        addr_d = address_i;
                        wdata_d = value_i;
                    end
                    OP_READ: begin
                        state_d = RD;
                        req_d = 1'b1;
                        we_d = 1'b0;
                        addr_d = address_i;
                    end
                    OP_STREAM: begin
                        // read-back address is captured now so a later rebind cannot redirect it
                        if (rd_ok_q && wr_ok_q) begin
                            state_d = ST_WR;
                            req_d = 1'b1;
                            we_d = 1'b1;
                            addr_d = bind_wr_q;
                            wdata_d = value_i;
                            st_addr_d = bind_rd_q;
                        end else begin
                            err_d[ERR_UNBOUND] = 1'b1;
                        end
                    end
                    OP_BIND_READ: begin
                        bind_rd_d = address_i;
                        rd_ok_d = 1'b1;
                    end
                    OP_BIND_WRITE: begin
                        bind_wr_d = address_i;
                        wr_ok_d = 1'b1;
                    end
                    OP_BIND_INTR: begin
                        intr_addr_d = address_i;
                        intr_en_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (!req_q) begin
            req_d = 1'b1;
        end else if (mem.ack) begin
            req_d = 1'b0;
            state_d = (state_q == ST_WR) ? ST_RD : IDLE;
            result_d = (state_q == RD) ? mem.rdata : result_q;
            stream_d = (state_q == ST_RD) ? mem.rdata : stream_q;
            we_d = (state_q == ST_WR) ? 1'b0 : we_q;
            addr_d = (state_q == ST_WR) ? st_addr_q : addr_q;
        end else if (expired) begin
            req_d = 1'b0;
            state_d = IDLE;
            err_d[ERR_TIMEOUT] = 1'b1;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            st_addr_q <= '0;
            result_q <= '0;
            stream_q <= '0;
            bind_rd_q <= '0;
            bind_wr_q <= '0;
            rd_ok_q <= 1'b0;
            wr_ok_q <= 1'b0;
            intr_addr_q <= '0;
            intr_en_q <= 1'b0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            st_addr_q <= st_addr_d;
            result_q <= result_d;
            stream_q <= stream_d;
            bind_rd_q <= bind_rd_d;
            bind_wr_q <= bind_wr_d;
            rd_ok_q <= rd_ok_d;
            wr_ok_q <= wr_ok_d;
            intr_addr_q <= intr_addr_d;
            intr_en_q <= intr_en_d;
            err_q <= err_d;
        end
    end
    assign cmd_ready_o = state_q == IDLE;
    assign mem.req = req_q;
    assign mem.we = we_q;
    assign mem.addr = addr_q;
    assign mem.wdata = wdata_q;
    assign result_o = result_q;
    assign stream_o = stream_q;
    assign intr_addr_o = intr_addr_q;
    assign intr_en_o = intr_en_q;
    assign err_o = err_q;
endmodule
